mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared MIPS datapath: pc, instruction_memory, regfile, ALU, operand mux and datamem.
- Each instruction runs through FETCH/DECODE/EXEC/MEM/WB.
- The block drives every datapath enable and select, so the bench-driven control signals are replaced by decoded, timed strobes.
- It also traps illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- ALUOP_W, 8, width of the ALUop bus; matches the ALU.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- instr  in  32  instruction word from instruction_memory; sampled in FETCH.
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  datamem access complete (used only with MEM_WAIT_EN).
- stall  in  1  freeze request from the system.
- ALUop  out  ALUOP_W  ALU operation select.
- alu_src  out  1  0 = rdata2, 1 = sign-extended imm[15:0].
- reg_dst  out  1  write address select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-data select: 0 = ALUResult, 1 = datamem rdata.
- wren  out  1  regfile write strobe.
- mem_read  out  1  datamem read strobe.
- mem_write  out  1  datamem write strobe.
- instr_load  out  1  IR capture strobe.
- pc_write  out  1  PC update strobe.
- branch_taken  out  1  PC selects branch_address (valid with pc_write).
- jump_taken  out  1  PC selects jump_address (valid with pc_write).
- trap  out  1  illegal opcode seen; sticky.
- state  out  3  current FSM state, for debug.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0, async): state=FETCH; all outputs 0; retired=0; trap=0. Asserting reset mid-instruction aborts it with no write and no PC update.
- ALUop codes: ADD=0, SUB=1, AND=2, OR=3, XOR=5.
- Decode table:
  - R-type, op 0x00: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR.
  - I-type ALU: addi 0x08 ADD, andi 0x0C AND, ori 0x0D OR.
  - Memory: lw 0x23, sw 0x2B, both use ADD with alu_src=1.
  - Branches: beq 0x04, bne 0x05, both use SUB with alu_src=0.
  - Jump: j 0x02.
  - Any other op, or an unknown funct under op 0x00, is illegal.
- FETCH: instr_load=1 for 1 cycle, opcode/funct registered internally -> DECODE.
- DECODE: ALUop, alu_src, reg_dst and mem_to_reg are set here and held through the rest of the instruction. Next state:
  - illegal -> TRAP;
  - otherwise -> EXEC.
- EXEC (ALU result valid):
  - beq: pc_write=1, branch_taken=zero -> FETCH.
  - bne: pc_write=1, branch_taken=~zero -> FETCH.
  - j: pc_write=1, jump_taken=1 -> FETCH.
  - lw/sw -> MEM.
  - ALU ops -> WB.
- MEM:
  - lw: mem_read=1 -> WB.
  - sw: mem_write=1, pc_write=1 -> FETCH.
- WB: wren=1, pc_write=1 -> FETCH. mem_to_reg=1 for lw only.
- TRAP: trap=1; all strobes 0; state held until reset. Not counted as retired.
- Latency in cycles: ALU ops 4; lw 5; sw 4; beq/bne/j 3.
- Strobes are 1-cycle pulses: wren, mem_read, mem_write, instr_load, pc_write, branch_taken, jump_taken.
- retired increments by 1 on every cycle with pc_write=1 and wraps at 2^CNT_W-1 -> 0.
- stall=1:
  - state is held;
  - all strobes are forced to 0;
  - level selects are held;
  - the pending step re-executes after stall falls.
- Stall vs reset: reset has priority over stall.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined: the FSM stays in MEM while mem_ready=0, holding mem_read or mem_write high. It advances on the first cycle with mem_ready=1, and the sw pc_write is issued in that cycle. stall still overrides.
- Undefined: MEM always takes 1 cycle and mem_ready is ignored.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - ALUop codes;
  - 3-bit state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Sub-module mips_alu_decoder (combinational): inputs opcode and funct; outputs ALUop, alu_src, reg_dst, mem_to_reg and illegal.

Test Plan:
- add r3,r1,r2 with r1=10, r2=20 -> FETCH..WB in 4 cycles; ALUop=0, reg_dst=1, wren pulse; ALUResult=30; retired=1.
- sw r2,4(r0) then lw r4,4(r0) -> sw: mem_write in cycle 4, 4 cycles total. lw: mem_read in cycle 4, wren with mem_to_reg=1 in cycle 5; r4=20.
- beq r1,r2 (10 vs 20) -> branch_taken=0. bne with the same operands -> branch_taken=1 with pc_write. Each takes 3 cycles.
- instr=0xFC000000 (op 0x3F) -> trap=1 after DECODE; no strobes for 20 cycles. Then reset=0 -> trap=0, state=FETCH.
- stall=1 for 3 cycles during WB of addi -> no wren while stalled; exactly one wren after release; retired +1.
- MEM_WAIT_EN build, lw with mem_ready low for 2 cycles -> mem_read high 3 cycles; WB follows; lw takes 7 cycles.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs, ALU codes, FSM states.
// The optional MEM_WAIT_EN macro is consumed by the top-level controller, not here.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnXor = 6'h26;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluXor = 3'd5;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational opcode/funct decoder producing ALU operation, operand/write selects and an
// illegal-instruction flag.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 8
) (
  input  logic [5:0]         opcode_i,
  input  logic [5:0]         funct_i,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               alu_src_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               illegal_o
);

  logic [2:0] code;

  always_comb begin
    code         = AluAdd;
    alu_src_o    = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_o    = 1'b0;
    case (opcode_i)
      OpRtype: begin
        reg_dst_o = 1'b1;
        case (funct_i)
          FnAdd:   code = AluAdd;
          FnSub:   code = AluSub;
          FnAnd:   code = AluAnd;
          FnOr:    code = AluOr;
          FnXor:   code = AluXor;
          default: begin
            reg_dst_o = 1'b0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OpAddi: begin
        code      = AluAdd;
        alu_src_o = 1'b1;
      end
      OpAndi: begin
        code      = AluAnd;
        alu_src_o = 1'b1;
      end
      OpOri: begin
        code      = AluOr;
        alu_src_o = 1'b1;
      end
      OpLw: begin
        code         = AluAdd;
        alu_src_o    = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      OpSw: begin
        code      = AluAdd;
        alu_src_o = 1'b1;
      end
      OpBeq, OpBne: code = AluSub;
      OpJ:          code = AluAdd;
      default:      illegal_o = 1'b1;
    endcase
  end

  assign alu_op_o = ALUOP_W'(code);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the shared MIPS datapath.
// Define MEM_WAIT_EN to make MEM wait on mem_ready; otherwise MEM is a single cycle.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned ALUOP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               stall,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               alu_src,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               wren,
  output logic               mem_read,
  output logic               mem_write,
  output logic               instr_load,
  output logic               pc_write,
  output logic               branch_taken,
  output logic               jump_taken,
  output logic               trap,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q, state_d;
  logic [5:0]         opcode_q, opcode_d, funct_q, funct_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic               alu_src_q, alu_src_d, reg_dst_q, reg_dst_d, mem_to_reg_q, mem_to_reg_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_alu_src, dec_reg_dst, dec_mem_to_reg, dec_illegal;
  logic               mem_done;
  logic               s_wren, s_mem_read, s_mem_write, s_instr_load, s_pc_write, s_branch, s_jump;
  logic               strobe_en;

  mips_alu_decoder #(
    .ALUOP_W(ALUOP_W)
  ) u_dec (
    .opcode_i    (opcode_q),
    .funct_i     (funct_q),
    .alu_op_o    (dec_aluop),
    .alu_src_o   (dec_alu_src),
    .reg_dst_o   (dec_reg_dst),
    .mem_to_reg_o(dec_mem_to_reg),
    .illegal_o   (dec_illegal)
  );

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    aluop_d      = aluop_q;
    alu_src_d    = alu_src_q;
    reg_dst_d    = reg_dst_q;
    mem_to_reg_d = mem_to_reg_q;
    s_wren       = 1'b0;
    s_mem_read   = 1'b0;
    s_mem_write  = 1'b0;
    s_instr_load = 1'b0;
    s_pc_write   = 1'b0;
    s_branch     = 1'b0;
    s_jump       = 1'b0;
    case (state_q)
      StFetch: begin
        s_instr_load = 1'b1;
        opcode_d     = instr[31:26];
        funct_d      = instr[5:0];
        state_d      = StDecode;
      end
      StDecode: begin
        aluop_d      = dec_aluop;
        alu_src_d    = dec_alu_src;
        reg_dst_d    = dec_reg_dst;
        mem_to_reg_d = dec_mem_to_reg;
        state_d      = dec_illegal ? StTrap : StExec;
      end
      StExec: begin
        case (opcode_q)
          OpBeq: begin
            s_pc_write = 1'b1;
            s_branch   = zero;
            state_d    = StFetch;
          end
          OpBne: begin
            s_pc_write = 1'b1;
            s_branch   = ~zero;
            state_d    = StFetch;
          end
          OpJ: begin
            s_pc_write = 1'b1;
            s_jump     = 1'b1;
            state_d    = StFetch;
          end
          OpLw, OpSw: state_d = StMem;
          default:    state_d = StWb;
        endcase
      end
      StMem: begin
        if (opcode_q == OpLw) begin
          s_mem_read = 1'b1;
          if (mem_done) state_d = StWb;
        end else begin
          s_mem_write = 1'b1;
          if (mem_done) begin
            s_pc_write = 1'b1;
            state_d    = StFetch;
          end
        end
      end
      StWb: begin
        s_wren     = 1'b1;
        s_pc_write = 1'b1;
        state_d    = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase

    // A stalled cycle must leave every register untouched so the step replays afterwards.
    if (stall) begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      funct_d      = funct_q;
      aluop_d      = aluop_q;
      alu_src_d    = alu_src_q;
      reg_dst_d    = reg_dst_q;
      mem_to_reg_d = mem_to_reg_q;
    end
  end

  // Gating with reset keeps instr_load low while the FSM sits in FETCH under reset.
  assign strobe_en    = reset & ~stall;
  assign wren         = s_wren & strobe_en;
  assign mem_read     = s_mem_read & strobe_en;
  assign mem_write    = s_mem_write & strobe_en;
  assign instr_load   = s_instr_load & strobe_en;
  assign pc_write     = s_pc_write & strobe_en;
  assign branch_taken = s_branch & strobe_en;
  assign jump_taken   = s_jump & strobe_en;

  assign retired_d = retired_q + CNT_W'(pc_write);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFetch;
      opcode_q     <= '0;
      funct_q      <= '0;
      aluop_q      <= '0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      funct_q      <= funct_d;
      aluop_q      <= aluop_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      retired_q    <= retired_d;
    end
  end

  // Selects become visible in DECODE itself, then come from the held copies.
  assign ALUop      = (state_q == StDecode) ? dec_aluop : aluop_q;
  assign alu_src    = (state_q == StDecode) ? dec_alu_src : alu_src_q;
  assign reg_dst    = (state_q == StDecode) ? dec_reg_dst : reg_dst_q;
  assign mem_to_reg = (state_q == StDecode) ? dec_mem_to_reg : mem_to_reg_q;

  assign trap    = (state_q == StTrap);
  assign state   = state_q;
  assign retired = retired_q;

endmodule
